// File: rtl/seq_alu_if.sv
// seq_alu command/result interface.
// The master drives commands and accepts results; the slave is the ALU.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_sel;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, a, b, alu_sel, acc_sel, out_ready,
    input  in_ready, out_valid, result, carry, zero, ovf, err, busy
  );

  modport slave (
    input  in_valid, a, b, alu_sel, acc_sel, out_ready,
    output in_ready, out_valid, result, carry, zero, ovf, err, busy
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with valid/ready handshake, an iterative
// shift-add multiplier and an accumulator mode (result register as operand A).
// Define SEQ_ALU_DIV_EN to build the iterative restoring divider for op 3;
// without it op 3 completes in one cycle with result 0 and err set.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpMul  = 4'h2;
  localparam logic [3:0] OpDiv  = 4'h3;
  localparam logic [3:0] OpShl  = 4'h4;
  localparam logic [3:0] OpShr  = 4'h5;
  localparam logic [3:0] OpRol  = 4'h6;
  localparam logic [3:0] OpRor  = 4'h7;
  localparam logic [3:0] OpAnd  = 4'h8;
  localparam logic [3:0] OpOr   = 4'h9;
  localparam logic [3:0] OpXor  = 4'hA;
  localparam logic [3:0] OpNor  = 4'hB;
  localparam logic [3:0] OpNand = 4'hC;
  localparam logic [3:0] OpXnor = 4'hD;
  localparam logic [3:0] OpGt   = 4'hE;
  localparam logic [3:0] OpEq   = 4'hF;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d;   // mul: upper product half; div: remainder
  logic [WIDTH-1:0]  lo_q, lo_d;   // mul: multiplier/lower half; div: dividend/quotient
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
`endif

  logic [WIDTH-1:0]  opa;
  logic              iter_op;
  logic [WIDTH:0]    sum_ext;
  logic [WIDTH:0]    diff_ext;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;
  logic              alu_ovf;
  logic              alu_err;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  step_hi;
  logic [WIDTH-1:0]  step_lo;

  // Accumulator mode replaces operand A with the previous result.
  assign opa = bus.acc_sel ? result_q : bus.a;

`ifdef SEQ_ALU_DIV_EN
  assign iter_op = (bus.alu_sel == OpMul) || (bus.alu_sel == OpDiv);
`else
  assign iter_op = (bus.alu_sel == OpMul);
`endif

  // Single-cycle operations and their flags.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    sum_ext   = {1'b0, opa} + {1'b0, bus.b};
    diff_ext  = {1'b0, opa} - {1'b0, bus.b};
    case (bus.alu_sel)
      OpAdd: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (opa[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OpSub: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (opa[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OpDiv: begin
`ifndef SEQ_ALU_DIV_EN
        alu_err = 1'b1;
`endif
      end
      OpShl: begin
        alu_res   = {opa[WIDTH-2:0], 1'b0};
        alu_carry = opa[WIDTH-1];
      end
      OpShr: begin
        alu_res   = {1'b0, opa[WIDTH-1:1]};
        alu_carry = opa[0];
      end
      OpRol:  alu_res = {opa[WIDTH-2:0], opa[WIDTH-1]};
      OpRor:  alu_res = {opa[0], opa[WIDTH-1:1]};
      OpAnd:  alu_res = opa & bus.b;
      OpOr:   alu_res = opa | bus.b;
      OpXor:  alu_res = opa ^ bus.b;
      OpNor:  alu_res = ~(opa | bus.b);
      OpNand: alu_res = ~(opa & bus.b);
      OpXnor: alu_res = ~(opa ^ bus.b);
      OpGt:   alu_res = {{(WIDTH-1){1'b0}}, opa > bus.b};
      OpEq:   alu_res = {{(WIDTH-1){1'b0}}, opa == bus.b};
      default: ;
    endcase
  end

  // One iteration of the shift-add multiplier (or restoring divider).
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opa_q : {WIDTH{1'b0}})};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      if (div_shift >= {1'b0, opb_q}) begin
        step_hi = div_diff;
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opa_d    = opa_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef SEQ_ALU_DIV_EN
    opb_d    = opb_q;
    is_div_d = is_div_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (iter_op) begin
            state_d = StBusy;
            opa_d   = opa;
            hi_d    = '0;
            lo_d    = bus.b;
            cnt_d   = '0;
`ifdef SEQ_ALU_DIV_EN
            opb_d    = bus.b;
            is_div_d = (bus.alu_sel == OpDiv);
            if (bus.alu_sel == OpDiv) begin
              lo_d = opa;
            end
`endif
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            err_d    = alu_err;
          end
        end
      end
      StBusy: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) begin
          state_d  = StDone;
          result_d = step_lo;
          zero_d   = (step_lo == '0);
          ovf_d    = 1'b0;
          carry_d  = |step_hi;
          err_d    = 1'b0;
`ifdef SEQ_ALU_DIV_EN
          if (is_div_q) begin
            carry_d = 1'b0;
            err_d   = (opb_q == '0);
          end
`endif
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset clears everything including the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      opb_q    <= '0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opa_q    <= opa_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef SEQ_ALU_DIV_EN
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StBusy);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized commands
// checked against an arithmetic reference model with an accumulator shadow.
module tb_seq_alu;
  localparam int unsigned W = 8;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0]   acc_model;
  logic [W+3:0]   exp_vec, obs_vec;   // {result, carry, zero, ovf, err}
  int             exp_lat, obs_lat, exp_busy, obs_busy;

  // Reference model from the operation table, using plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [3:0] sel, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    int unsigned x, y, m, r;
    int sx, sy, sr, half;
    logic c, o, e;
    logic [W-1:0] res;
    m = 1 << W;
    half = int'(m / 2);
    x = av;
    y = bv;
    sx = (x >= m / 2) ? int'(x) - int'(m) : int'(x);
    sy = (y >= m / 2) ? int'(y) - int'(m) : int'(y);
    c = 1'b0; o = 1'b0; e = 1'b0; r = 0;
    case (sel)
      4'h0: begin r = x + y; c = (r >= m); sr = sx + sy; o = (sr >= half) || (sr < -half); end
      4'h1: begin r = x + m - y; c = (x < y); sr = sx - sy; o = (sr >= half) || (sr < -half); end
      4'h2: begin r = x * y; c = (r >= m); end
      4'h3: begin
        if (!DivEn) begin r = 0; e = 1'b1; end
        else if (y == 0) begin r = m - 1; e = 1'b1; end
        else r = x / y;
      end
      4'h4: begin r = x * 2; c = (x >= m / 2); end
      4'h5: begin r = x / 2; c = ((x % 2) == 1); end
      4'h6: r = x * 2 + x / (m / 2);
      4'h7: r = x / 2 + (x % 2) * (m / 2);
      4'h8: r = x & y;
      4'h9: r = x | y;
      4'hA: r = x ^ y;
      4'hB: r = ~(x | y);
      4'hC: r = ~(x & y);
      4'hD: r = ~(x ^ y);
      4'hE: r = (x > y) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
    res = W'(r % m);
    return {res, c, (res == '0), o, e};
  endfunction

  // Issue one command and wait (bounded) for its result; leaves the result pending.
  task automatic run_cmd(input logic [3:0] sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic acc);
    int guard;
    bus.alu_sel = sel;
    bus.a       = av;
    bus.b       = bv;
    bus.acc_sel = acc;
    exp_vec  = model(sel, acc ? acc_model : av, bv);
    exp_lat  = ((sel == 4'h2) || (DivEn && sel == 4'h3)) ? W + 1 : 1;
    exp_busy = (exp_lat == 1) ? 0 : W;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_wait: got %b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    obs_lat  = 1;
    obs_busy = 0;
    while (bus.out_valid !== 1'b1 && obs_lat < 64) begin
      if (bus.busy === 1'b1) obs_busy++;
      @(posedge clk); #1; obs_lat++;
    end
    obs_vec   = {bus.result, bus.carry, bus.zero, bus.ovf, bus.err};
    acc_model = exp_vec[W+3:4];
  endtask

  task automatic accept_result(input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    bus.alu_sel = '0; bus.acc_sel = 1'b0;
    rst = 1'b1;
    acc_model = '0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if ({bus.out_valid, bus.busy, bus.result, bus.carry, bus.zero, bus.ovf, bus.err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v%b b%b r%h flags %b required all 0", bus.out_valid,
               bus.busy, bus.result, {bus.carry, bus.zero, bus.ovf, bus.err});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_single_cycle;
    logic [W-1:0] want [4];
    logic [3:0]   sel  [4];
    logic [W-1:0] av   [4];
    logic [W-1:0] bv   [4];
    want = '{8'h0C, 8'hFF, 8'h80, 8'h00};
    sel  = '{4'h0, 4'h1, 4'h0, 4'hD};
    av   = '{8'h0A, 8'h02, 8'h7F, 8'hFF};
    bv   = '{8'h02, 8'h03, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) begin
      run_cmd(sel[i], av[i], bv[i], 1'b0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL single_%0d_flags: got %h required %h", i, obs_vec, exp_vec);
      end
      n_vec++;
      if (obs_vec[W+3:4] !== want[i]) begin
        n_err++; $display("FAIL single_%0d_result: got %h required %h", i, obs_vec[W+3:4], want[i]);
      end
      n_vec++;
      if (obs_lat != 1) begin
        n_err++; $display("FAIL single_%0d_latency: got %0d required 1", i, obs_lat);
      end
      accept_result(0);
    end
  endtask

  task automatic test_mul;
    run_cmd(4'h2, 8'h0A, 8'h02, 1'b0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[W+3:4] !== 8'h14) begin
      n_err++; $display("FAIL mul_basic: got %h required %h", obs_vec, exp_vec);
    end
    n_vec++;
    if (obs_lat != W + 1 || obs_busy != W) begin
      n_err++; $display("FAIL mul_timing: got lat %0d busy %0d required %0d %0d", obs_lat,
                        obs_busy, W + 1, W);
    end
    accept_result(1);
    run_cmd(4'h2, 8'h10, 8'h10, 1'b0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[W+3] !== 1'b0 || obs_vec[3] !== 1'b1) begin
      n_err++; $display("FAIL mul_carry: got %h required %h", obs_vec, exp_vec);
    end
    accept_result(0);
  endtask

  task automatic test_div;
    logic [W-1:0] want_q;
    want_q = DivEn ? 8'h05 : 8'h00;
    run_cmd(4'h3, 8'h0A, 8'h02, 1'b0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[W+3:4] !== want_q) begin
      n_err++; $display("FAIL div_basic: got %h required %h", obs_vec, exp_vec);
    end
    n_vec++;
    if (obs_lat != exp_lat || obs_busy != exp_busy) begin
      n_err++; $display("FAIL div_timing: got lat %0d busy %0d required %0d %0d", obs_lat,
                        obs_busy, exp_lat, exp_busy);
    end
    accept_result(0);
    run_cmd(4'h3, 8'h0A, 8'h00, 1'b0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[0] !== 1'b1) begin
      n_err++; $display("FAIL div_by_zero: got %h required %h", obs_vec, exp_vec);
    end
    accept_result(0);
  endtask

  task automatic test_accumulate_backpressure;
    logic [W+3:0] held;
    run_cmd(4'h0, 8'h0A, 8'h02, 1'b0);
    accept_result(0);
    run_cmd(4'h0, 8'hEE, 8'h03, 1'b1);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[W+3:4] !== 8'h0F) begin
      n_err++; $display("FAIL acc_add: got %h required %h", obs_vec, exp_vec);
    end
    held = exp_vec;
    // A new command waits on the input while the result is held off.
    bus.alu_sel = 4'hA; bus.a = 8'h5A; bus.b = 8'hFF; bus.acc_sel = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.zero, bus.ovf, bus.err}
          !== {1'b1, 1'b0, held}) begin
        n_err++; $display("FAIL stall_%0d: got v%b rdy%b %h required v1 rdy0 %h", i,
                          bus.out_valid, bus.in_ready, {bus.result, bus.carry, bus.zero,
                          bus.ovf, bus.err}, held);
      end
    end
    accept_result(0);
    run_cmd(4'hA, 8'h5A, 8'hFF, 1'b0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_lat != 1) begin
      n_err++; $display("FAIL held_cmd: got %h lat %0d required %h lat 1", obs_vec, obs_lat,
                        exp_vec);
    end
    accept_result(0);
  endtask

  task automatic test_reset_mid_op;
    bus.alu_sel = 4'h2; bus.a = 8'h33; bus.b = 8'h44; bus.acc_sel = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.busy, bus.result, bus.carry, bus.zero, bus.ovf, bus.err} !== '0) begin
      n_err++; $display("FAIL midreset_outputs: got v%b b%b r%h required 0", bus.out_valid,
                        bus.busy, bus.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    acc_model = '0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_ready: got rdy%b v%b required rdy1 v0", bus.in_ready,
                        bus.out_valid);
    end
    run_cmd(4'h0, 8'h01, 8'h01, 1'b0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[W+3:4] !== 8'h02) begin
      n_err++; $display("FAIL midreset_add: got %h required %h", obs_vec, exp_vec);
    end
    accept_result(0);
  endtask

  task automatic test_first_acc_after_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_model = '0;
    run_cmd(4'h0, 8'hA5, 8'h07, 1'b1);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec[W+3:4] !== 8'h07) begin
      n_err++; $display("FAIL acc_after_reset: got %h required %h", obs_vec, exp_vec);
    end
    accept_result(0);
  endtask

  task automatic test_random;
    logic [3:0]   sel;
    logic [W-1:0] av, bv;
    logic         acc;
    for (int i = 0; i < 40; i++) begin
      sel = 4'($urandom_range(0, 15));
      av  = W'($urandom);
      bv  = W'($urandom);
      acc = 1'($urandom_range(0, 1));
      run_cmd(sel, av, bv, acc);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL rand_%0d op%h a%h b%h acc%b: got %h required %h", i, sel, av, bv,
                          acc, obs_vec, exp_vec);
      end
      n_vec++;
      if (obs_lat != exp_lat || obs_busy != exp_busy) begin
        n_err++; $display("FAIL rand_%0d_timing: got lat %0d busy %0d required %0d %0d", i,
                          obs_lat, obs_busy, exp_lat, exp_busy);
      end
      accept_result($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_accumulate_backpressure();
    test_reset_mid_op();
    test_first_acc_after_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
